// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder, condition check and flag register.
// Instr is the instruction register; it must hold steady from DECODE to the end of the instruction.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q;
  logic        condExR_q;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        rdIsPc;
  logic        unusedInstrBits;

  logic        nextPc, regW, memW, branch, aluOp, irW;
  logic        isAddSub, condEx;
  logic [1:0]  flagW;
  logic        pcs;
  logic        flagN, flagZ, flagC, flagV;

  assign cond            = Instr[31:28];
  assign op              = Instr[27:26];
  assign funct           = Instr[25:20];
  assign rdIsPc          = (Instr[15:12] == 4'hF);
  assign unusedInstrBits = ^{Instr[19:16], Instr[11:0]};
  assign {flagN, flagZ, flagC, flagV} = flags_q;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Raw per-state controls before condition gating.
  always_comb begin
    nextPc    = 1'b0;
    regW      = 1'b0;
    memW      = 1'b0;
    branch    = 1'b0;
    aluOp     = 1'b0;
    irW       = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        irW = 1'b1; nextPc = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01; regW = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1; memW = 1'b1;
      end
      EXECUTER: aluOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01; aluOp = 1'b1;
      end
      ALUWB:    regW = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    isAddSub   = 1'b0;
    if (aluOp) begin
      case (funct[4:1])
        4'b0100: begin ALUControl = 2'b00; isAddSub = 1'b1; end
        4'b0010: begin ALUControl = 2'b01; isAddSub = 1'b1; end
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
    end
    flagW[1] = aluOp & funct[0];
    flagW[0] = aluOp & funct[0] & isAddSub;
  end

  always_comb begin
    case (cond)
      4'h0:    condEx = flagZ;
      4'h1:    condEx = ~flagZ;
      4'h2:    condEx = flagC;
      4'h3:    condEx = ~flagC;
      4'h4:    condEx = flagN;
      4'h5:    condEx = ~flagN;
      4'h6:    condEx = flagV;
      4'h7:    condEx = ~flagV;
      4'h8:    condEx = flagC & ~flagZ;
      4'h9:    condEx = ~flagC | flagZ;
      4'hA:    condEx = (flagN == flagV);
      4'hB:    condEx = (flagN != flagV);
      4'hC:    condEx = ~flagZ & (flagN == flagV);
      4'hD:    condEx = flagZ | (flagN != flagV);
      4'hE:    condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // The condition is frozen at the end of DECODE so the flag update cannot change its own instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      condExR_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        condExR_q <= condEx;
      if (condExR_q && flagW[1])
        flags_q[3:2] <= ALUFlags[3:2];
      if (condExR_q && flagW[0])
        flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs      = (regW & rdIsPc) | branch;
  assign PCWrite  = reset & (nextPc | (pcs & condExR_q));
  assign RegWrite = reset & regW & condExR_q & ~rdIsPc;
  assign MemWrite = reset & memW & condExR_q;
  assign IRWrite  = reset & irW;
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};

endmodule
